mem_arbiter: RTL
================

# mem_arbiter

Single-port memory bus arbiter for the openmips core. Shares one external memory bus between the instruction-fetch requester (PC/IF stage) and the data requester (MEM stage). Runs each granted transfer to completion with a wait-state timeout and drives a stall request to the pipeline while any requester waits. Sits between the core's fetch and memory ports and the SoC memory/ROM.

## Interface
Parameters:
- TIMEOUT, 15: maximum cycles in a transfer without `bus_ack_i` before abort; legal range 2..255.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  **asynchronous, active-low** reset.
- if_req_i  in  1  fetch request; held high until `if_ack_o`.
- if_addr_i  in  32  fetch address.
- if_data_o  out  32  fetched instruction; valid while `if_ack_o`.
- if_ack_o  out  1  one-cycle fetch completion pulse.
- dm_req_i  in  1  data request; held high until `dm_ack_o`.
- dm_we_i  in  1  1 = write, 0 = read.
- dm_sel_i  in  4  byte enables.
- dm_addr_i  in  32  data address.
- dm_wdata_i  in  32  write data.
- dm_rdata_o  out  32  read data; valid while `dm_ack_o`.
- dm_ack_o  out  1  one-cycle data completion pulse.
- bus_ce_o, bus_we_o  out  1  memory chip-enable and write strobe.
- bus_sel_o  out  4  byte enables.
- bus_addr_o, bus_wdata_o  out  32  address and write data.
- bus_rdata_i  in  32  read data; sampled when `bus_ack_i`.
- bus_ack_i  in  1  memory completion.
- err_o  out  1  one-cycle pulse on timeout abort.
- stallreq_o  out  1  pipeline stall request.

## Operation
- States: IDLE, IF_XFER, DM_XFER.
- Grant, evaluated in IDLE and on the completing cycle of a transfer:
  - Only one request pending: that requester wins.
  - Both pending: DM wins (fixed priority; see Configuration).
- On grant, register the winner's address, sel, we, and wdata onto the bus outputs and set `bus_ce_o` = 1. For IF, `bus_we_o` = 0 and `bus_sel_o` = 4'hF. Bus outputs stay stable for the whole transfer.
- In XFER, when `bus_ack_i` = 1:
  - Capture `bus_rdata_i` into the granted requester's data output.
  - Pulse its ack next cycle.
  - Clear the wait counter.
  - Re-arbitrate: if the other requester is pending, grant it directly (back-to-back, no dead cycle); otherwise go to IDLE with `bus_ce_o` = 0.
- The finished requester's `req_i` is ignored in the cycle its ack is high, so it cannot be re-granted on a stale request.
- Timeout: the wait counter increments every XFER cycle without `bus_ack_i`. When it reaches TIMEOUT:
  - Abort the transfer and drop `bus_ce_o`.
  - Pulse the requester's ack with data 32'h0.
  - Pulse `err_o`.
- Ack and timeout in the same cycle: ack wins, no `err_o`.
- Requesters dropping `req_i` mid-transfer is illegal; the arbiter completes the transfer regardless.
- `stallreq_o` = (`if_req_i` & ~`if_ack_o`) | (`dm_req_i` & ~`dm_ack_o`), combinational.
- Wait counter width is clog2(TIMEOUT+1); it saturates and never wraps.

## Timing
- Reset values: all outputs 0, state IDLE, counter 0.
- Reset asserted mid-transfer: bus released immediately (asynchronous), no ack or err issued, and the pending request is re-arbitrated after release.
- Minimum latency, request in cycle 0 with zero-wait memory:
  - `bus_ce_o` high in cycle 1.
  - `bus_ack_i` sampled in cycle 1.
  - Ack/data out in cycle 2.
- N wait states add N cycles.
- Ack and data outputs are registered. Data outputs hold their last value after ack.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin arbitration. A 1-bit last-grant register, reset to IF, makes simultaneous requests go to the requester not granted last.
- Not defined: fixed DM-over-IF priority and no last-grant register.

## Structure
- State encodings, ChipEnable/ChipDisable, WriteEnable, and bus widths (RegBus, InstAddrBus) come from `define.v`. New state encodings are added there with the prefix ARB_.
- One sub-module, `mem_arb_grant`: combinational grant selection, with the `MEM_ARB_RR_EN` logic inside it.
- FSM, counter, and bus registers stay in `mem_arbiter`.

## Test plan
- IF-only fetch, addr 32'h0000_0004, memory acks in its first cycle with 32'h3401_1100 → `if_ack_o` pulses in cycle 2 with `if_data_o` = 32'h3401_1100; `stallreq_o` high in cycles 0–1.
- Simultaneous IF read and DM write (addr 32'h10, data 32'hDEAD_BEEF, sel 4'hF), fixed priority:
  - DM transfer first, then IF back-to-back with no idle cycle.
  - With `MEM_ARB_RR_EN` and last grant = DM: IF goes first.
- DM read with 3 wait states → `dm_ack_o` in cycle 5; bus signals constant in cycles 1–4.
- No ack for TIMEOUT = 15 cycles → `err_o` and `dm_ack_o` pulse together with `dm_rdata_o` = 0; `bus_ce_o` falls; a pending IF is then granted.
- `rst` driven low during a DM wait state → all bus outputs 0 at once; after release, the held request completes normally with no `err_o`.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the openmips memory bus arbiter.
package mem_arbiter_pkg;

  localparam int REG_BUS = 32;

  localparam logic CHIP_ENABLE   = 1'b1;
  localparam logic CHIP_DISABLE  = 1'b0;
  localparam logic WRITE_DISABLE = 1'b0;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_IF_XFER = 2'd1,
    ARB_DM_XFER = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_arb_grant.sv
// Combinational grant selection between fetch and data requesters.
// MEM_ARB_RR_EN selects round-robin on collision; otherwise DM has fixed priority.
module mem_arb_grant (
  input  logic if_req_i,
  input  logic dm_req_i,
`ifdef MEM_ARB_RR_EN
  input  logic last_dm_i,
`endif
  output logic gnt_if_o,
  output logic gnt_dm_o
);

  always_comb begin
    gnt_if_o = 1'b0;
    gnt_dm_o = 1'b0;
    if (if_req_i && dm_req_i) begin
`ifdef MEM_ARB_RR_EN
      // Collision goes to whoever was not served last.
      gnt_if_o = last_dm_i;
      gnt_dm_o = ~last_dm_i;
`else
      gnt_dm_o = 1'b1;
`endif
    end else begin
      gnt_if_o = if_req_i;
      gnt_dm_o = dm_req_i;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory bus arbiter: fetch vs data requester, wait-state timeout, stall request.
// Build option: MEM_ARB_RR_EN enables round-robin arbitration with a last-grant register.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_req_i,
  input  logic [REG_BUS-1:0] if_addr_i,
  output logic [REG_BUS-1:0] if_data_o,
  output logic               if_ack_o,
  input  logic               dm_req_i,
  input  logic               dm_we_i,
  input  logic [3:0]         dm_sel_i,
  input  logic [REG_BUS-1:0] dm_addr_i,
  input  logic [REG_BUS-1:0] dm_wdata_i,
  output logic [REG_BUS-1:0] dm_rdata_o,
  output logic               dm_ack_o,
  output logic               bus_ce_o,
  output logic               bus_we_o,
  output logic [3:0]         bus_sel_o,
  output logic [REG_BUS-1:0] bus_addr_o,
  output logic [REG_BUS-1:0] bus_wdata_o,
  input  logic [REG_BUS-1:0] bus_rdata_i,
  input  logic               bus_ack_i,
  output logic               err_o,
  output logic               stallreq_o,
  output logic [1:0]         dbg_state_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

  arb_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic               bus_ce_q, bus_ce_d, bus_we_q, bus_we_d;
  logic [3:0]         bus_sel_q, bus_sel_d;
  logic [REG_BUS-1:0] bus_addr_q, bus_addr_d, bus_wdata_q, bus_wdata_d;
  logic               if_ack_q, if_ack_d, dm_ack_q, dm_ack_d, err_q, err_d;
  logic [REG_BUS-1:0] if_data_q, if_data_d, dm_data_q, dm_data_d;
  logic               arb_if_req, arb_dm_req, gnt_if, gnt_dm, do_arb;
`ifdef MEM_ARB_RR_EN
  logic               last_dm_q, last_dm_d;
`endif

  // A requester is never eligible while it owns the bus or while its ack is high.
  assign arb_if_req = if_req_i & ~if_ack_q & (state_q != ARB_IF_XFER);
  assign arb_dm_req = dm_req_i & ~dm_ack_q & (state_q != ARB_DM_XFER);
  assign cnt_inc    = (cnt_q == TMO) ? cnt_q : cnt_q + CNT_W'(1);

  mem_arb_grant u_grant (
    .if_req_i  (arb_if_req),
    .dm_req_i  (arb_dm_req),
`ifdef MEM_ARB_RR_EN
    .last_dm_i (last_dm_q),
`endif
    .gnt_if_o  (gnt_if),
    .gnt_dm_o  (gnt_dm)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bus_ce_d    = bus_ce_q;
    bus_we_d    = bus_we_q;
    bus_sel_d   = bus_sel_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    err_d       = 1'b0;
    if_data_d   = if_data_q;
    dm_data_d   = dm_data_q;
    do_arb      = 1'b0;
`ifdef MEM_ARB_RR_EN
    last_dm_d   = last_dm_q;
`endif
    case (state_q)
      ARB_IDLE: do_arb = 1'b1;
      ARB_IF_XFER: begin
        if (bus_ack_i) begin
          if_ack_d  = 1'b1;
          if_data_d = bus_rdata_i;
          cnt_d     = '0;
          do_arb    = 1'b1;
        end else if (cnt_inc == TMO) begin
          if_ack_d  = 1'b1;
          if_data_d = '0;
          err_d     = 1'b1;
          cnt_d     = '0;
          state_d   = ARB_IDLE;
          bus_ce_d  = CHIP_DISABLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ARB_DM_XFER: begin
        if (bus_ack_i) begin
          dm_ack_d  = 1'b1;
          dm_data_d = bus_rdata_i;
          cnt_d     = '0;
          do_arb    = 1'b1;
        end else if (cnt_inc == TMO) begin
          dm_ack_d  = 1'b1;
          dm_data_d = '0;
          err_d     = 1'b1;
          cnt_d     = '0;
          state_d   = ARB_IDLE;
          bus_ce_d  = CHIP_DISABLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = ARB_IDLE;
    endcase

    if (do_arb) begin
      if (gnt_dm) begin
        state_d     = ARB_DM_XFER;
        bus_ce_d    = CHIP_ENABLE;
        bus_we_d    = dm_we_i;
        bus_sel_d   = dm_sel_i;
        bus_addr_d  = dm_addr_i;
        bus_wdata_d = dm_wdata_i;
`ifdef MEM_ARB_RR_EN
        last_dm_d   = 1'b1;
`endif
      end else if (gnt_if) begin
        state_d     = ARB_IF_XFER;
        bus_ce_d    = CHIP_ENABLE;
        bus_we_d    = WRITE_DISABLE;
        bus_sel_d   = 4'hF;
        bus_addr_d  = if_addr_i;
        bus_wdata_d = '0;
`ifdef MEM_ARB_RR_EN
        last_dm_d   = 1'b0;
`endif
      end else begin
        state_d  = ARB_IDLE;
        bus_ce_d = CHIP_DISABLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ARB_IDLE;
      cnt_q       <= '0;
      bus_ce_q    <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_sel_q   <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      err_q       <= 1'b0;
      if_data_q   <= '0;
      dm_data_q   <= '0;
`ifdef MEM_ARB_RR_EN
      last_dm_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bus_ce_q    <= bus_ce_d;
      bus_we_q    <= bus_we_d;
      bus_sel_q   <= bus_sel_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
      err_q       <= err_d;
      if_data_q   <= if_data_d;
      dm_data_q   <= dm_data_d;
`ifdef MEM_ARB_RR_EN
      last_dm_q   <= last_dm_d;
`endif
    end
  end

  assign if_data_o   = if_data_q;
  assign if_ack_o    = if_ack_q;
  assign dm_rdata_o  = dm_data_q;
  assign dm_ack_o    = dm_ack_q;
  assign bus_ce_o    = bus_ce_q;
  assign bus_we_o    = bus_we_q;
  assign bus_sel_o   = bus_sel_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_wdata_o = bus_wdata_q;
  assign err_o       = err_q;
  assign dbg_state_o = state_q;
  assign stallreq_o  = (if_req_i & ~if_ack_q) | (dm_req_i & ~dm_ack_q);

endmodule
